// File: rtl/xcorr_scheduler.sv
// xcorr_scheduler: sequences one acquisition frame. It starts the mic capture,
// runs the shared cross-correlator over mic pairs 1..NPAIR, and streams the
// result frame to the UART sender. A frame is 0xA5, then one lag byte per pair,
// then an XOR checksum over every earlier byte.
// Optional feature macro: XCORR_SCHED_PEAK_TX_EN. When it is defined, each pair
// also sends its 16-bit peak magnitude, high byte first, after its lag byte.
module xcorr_scheduler #(
    parameter int NPAIR   = 6,
    parameter int W       = 16,
    parameter int TIMEOUT = 65535
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         abort,
    output logic         cap_start,
    input  logic         cap_done,
    output logic         xc_start,
    output logic [2:0]   xc_pair,
    input  logic         xc_done,
    input  logic [7:0]   xc_lag,
    input  logic [W-1:0] xc_peak,
    output logic [7:0]   tx_data,
    output logic         tx_valid,
    input  logic         tx_ready,
    output logic         busy,
    output logic         err
);

    typedef enum logic [2:0] {IDLE, CAPTURE, XC_RUN, XC_WAIT, TX, DONE} state_t;

`ifdef XCORR_SCHED_PEAK_TX_EN
    localparam int FLEN = 3 * NPAIR + 2;
`else
    localparam int FLEN = NPAIR + 2;
`endif
    localparam int              WCW       = $clog2(TIMEOUT + 1);
    localparam logic [WCW-1:0]  WAIT_LAST = WCW'(TIMEOUT - 1);
    localparam logic [4:0]      TX_LAST   = 5'(FLEN - 1);
    localparam logic [2:0]      PAIR_LAST = 3'(NPAIR);

    state_t         state, state_next;
    logic           expire;
    logic           cap_start_q;
    logic           abort_pend;
    logic           tx_fire;
    logic           wait_limit;
    logic [2:0]     pair;
    logic [4:0]     tx_idx;
    logic [7:0]     csum;
    logic [7:0]     tx_byte;
    logic [WCW-1:0] wait_cnt;
    logic [7:0]     lag_mem [8];
`ifdef XCORR_SCHED_PEAK_TX_EN
    logic [W-1:0]   peak_mem [8];
    logic [4:0]     body_idx;
    logic [2:0]     body_slot;
    logic [15:0]    body_peak;
`else
    logic           unused_peak;
    assign unused_peak = ^xc_peak;
`endif

    assign tx_fire    = (state == TX) && tx_ready;
    assign wait_limit = (wait_cnt == WAIT_LAST);

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next-state logic. expire marks the timeout transitions that set err.
    always_comb begin
        state_next = state;
        expire     = 1'b0;
        case (state)
            IDLE: if (start && !abort) state_next = CAPTURE;
            CAPTURE: begin
                if (abort)           state_next = IDLE;
                else if (cap_done)   state_next = XC_RUN;
                else if (wait_limit) begin state_next = IDLE; expire = 1'b1; end
            end
            XC_RUN: state_next = abort ? IDLE : XC_WAIT;
            XC_WAIT: begin
                if (abort)           state_next = IDLE;
                else if (xc_done)    state_next = (pair == PAIR_LAST) ? TX : XC_RUN;
                else if (wait_limit) begin state_next = IDLE; expire = 1'b1; end
            end
            TX: begin
                // An abort in TX is held back until the presented byte is taken.
                if (tx_ready) begin
                    if (abort || abort_pend)  state_next = IDLE;
                    else if (tx_idx == TX_LAST) state_next = DONE;
                end else if (wait_limit) begin
                    state_next = IDLE;
                    expire     = 1'b1;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output decode. tx_data is forced to zero whenever no byte is offered.
    always_comb begin
        cap_start = cap_start_q;
        xc_start  = (state == XC_RUN);
        xc_pair   = pair;
        busy      = (state != IDLE);
        tx_valid  = (state == TX);
        tx_data   = (state == TX) ? tx_byte : 8'h00;
    end

    // Select the frame byte for the current byte index.
    always_comb begin
        tx_byte = 8'hA5;
`ifdef XCORR_SCHED_PEAK_TX_EN
        body_idx  = tx_idx - 5'd1;
        body_slot = 3'(body_idx / 5'd3) + 3'd1;
        body_peak = 16'(peak_mem[body_slot]);
`endif
        if (tx_idx == TX_LAST) begin
            tx_byte = csum;
        end else if (tx_idx != 5'd0) begin
`ifdef XCORR_SCHED_PEAK_TX_EN
            case (body_idx % 5'd3)
                5'd0:    tx_byte = lag_mem[body_slot];
                5'd1:    tx_byte = body_peak[15:8];
                default: tx_byte = body_peak[7:0];
            endcase
`else
            tx_byte = lag_mem[tx_idx[2:0]];
`endif
        end
    end

    // Wait counter. It clears on every state change, and in TX it also clears on
    // each accepted byte, so the budget applies to each wait for tx_ready.
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt <= '0;
        end else if (state_next != state || tx_fire) begin
            wait_cnt <= '0;
        end else if (state == CAPTURE || state == XC_WAIT || (state == TX && !tx_ready)) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    // Frame datapath: capture pulse, pair counter, result slots, TX index and checksum.
    always_ff @(posedge clk) begin
        if (rst) begin
            cap_start_q <= 1'b0;
            err         <= 1'b0;
            pair        <= '0;
            tx_idx      <= '0;
            csum        <= '0;
            abort_pend  <= 1'b0;
            for (int unsigned i = 0; i < 8; i++) begin
                lag_mem[i] <= '0;
`ifdef XCORR_SCHED_PEAK_TX_EN
                peak_mem[i] <= '0;
`endif
            end
        end else begin
            cap_start_q <= (state == IDLE) && start && !abort;

            if (state == IDLE && start && !abort) err <= 1'b0;
            else if (expire)                      err <= 1'b1;

            if (state == CAPTURE && cap_done && !abort) pair <= 3'd1;

            if (state == XC_WAIT && xc_done && !abort) begin
                lag_mem[pair] <= xc_lag;
`ifdef XCORR_SCHED_PEAK_TX_EN
                peak_mem[pair] <= xc_peak;
`endif
                if (pair != PAIR_LAST) pair <= pair + 3'd1;
            end

            if (state != TX) begin
                tx_idx     <= '0;
                csum       <= '0;
                abort_pend <= 1'b0;
            end else begin
                if (abort) abort_pend <= 1'b1;
                if (tx_ready) begin
                    tx_idx <= tx_idx + 5'd1;
                    csum   <= csum ^ tx_byte;
                end
            end
        end
    end

endmodule

// File: tb/tb_xcorr_scheduler.sv
// Testbench for xcorr_scheduler. It uses a frame model built from the frame
// rules, a table of frame vectors with known checksums, and hand-written
// sequences for the abort, timeout and reset corner cases. It also runs
// randomized frames.
module tb_xcorr_scheduler;

    localparam int NP = 6;
`ifdef XCORR_SCHED_PEAK_TX_EN
    localparam int FLEN = 3 * NP + 2;
`else
    localparam int FLEN = NP + 2;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, start, abort, cap_done, xc_done, tx_ready;
    logic [7:0] xc_lag;
    logic [15:0] xc_peak;
    logic       cap_start, xc_start, tx_valid, busy, err;
    logic [2:0] xc_pair;
    logic [7:0] tx_data;

    logic       start_t;
    logic       cap_start_t, xc_start_t, tx_valid_t, busy_t, err_t;
    logic [2:0] xc_pair_t;
    logic [7:0] tx_data_t;

    xcorr_scheduler #(.NPAIR(NP), .W(16), .TIMEOUT(65535)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .cap_start(cap_start), .cap_done(cap_done),
        .xc_start(xc_start), .xc_pair(xc_pair), .xc_done(xc_done),
        .xc_lag(xc_lag), .xc_peak(xc_peak),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .busy(busy), .err(err)
    );

    xcorr_scheduler #(.NPAIR(NP), .W(16), .TIMEOUT(50)) dut_to (
        .clk(clk), .rst(rst), .start(start_t), .abort(abort),
        .cap_start(cap_start_t), .cap_done(cap_done),
        .xc_start(xc_start_t), .xc_pair(xc_pair_t), .xc_done(xc_done),
        .xc_lag(xc_lag), .xc_peak(xc_peak),
        .tx_data(tx_data_t), .tx_valid(tx_valid_t), .tx_ready(tx_ready),
        .busy(busy_t), .err(err_t)
    );

    typedef struct {
        logic [7:0] lag [8];
        int         rmode;
        int         cap_dly;
        logic [7:0] csum;
    } vec_t;

    int         n_chk = 0;
    int         n_err = 0;
    int         cyc = 0;
    int         rmode = 0;
    int         tv_cnt = 0;
    int         xs_t_cnt = 0;
    logic       hold_prev = 1'b0;
    logic [7:0] hold_data = 8'h00;
    logic [7:0] rx_q [$];
    logic [7:0] exp_q [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // tx_ready policy: 0 always ready, 1 toggle every 3 cycles, 2 driven by hand
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (rmode == 0)      tx_ready = 1'b1;
        else if (rmode == 1) tx_ready = (((cyc / 3) % 2) == 0);
    endtask

    // Byte collector and hold-stability checker, sampled mid-cycle
    always @(negedge clk) begin
        if (!rst) begin
            if (hold_prev) begin
                chk("hold_valid", tx_valid, 1);
                chk("hold_data", tx_data, hold_data);
            end
            if (tx_valid && tx_ready) rx_q.push_back(tx_data);
            if (tx_valid) tv_cnt++;
            if (xc_start_t) xs_t_cnt++;
            hold_prev = tx_valid && !tx_ready;
            hold_data = tx_data;
        end else begin
            hold_prev = 1'b0;
        end
    end

    // Reference frame: header, per-pair payload, XOR of everything before
    task automatic build_exp(input logic [7:0] lg [8], input logic [15:0] pk [8]);
        logic [7:0] cs;
        exp_q.delete();
        exp_q.push_back(8'hA5);
        for (int p = 1; p <= NP; p++) begin
            exp_q.push_back(lg[p]);
`ifdef XCORR_SCHED_PEAK_TX_EN
            exp_q.push_back(pk[p][15:8]);
            exp_q.push_back(pk[p][7:0]);
`endif
        end
        cs = 8'h00;
        foreach (exp_q[i]) cs = cs ^ exp_q[i];
        exp_q.push_back(cs);
    endtask

    task automatic wait_xc(output bit ok);
        int n;
        n = 0;
        while (!xc_start && n < 100) begin tick(); n++; end
        chk("xc_start_seen", xc_start, 1);
        ok = xc_start;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_cap_start"}, cap_start, 0);
        chk({tag, "_xc_start"}, xc_start, 0);
        chk({tag, "_xc_pair"}, xc_pair, 0);
        chk({tag, "_tx_valid"}, tx_valid, 0);
        chk({tag, "_tx_data"}, tx_data, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_err"}, err, 0);
    endtask

    // Start a frame, finish the capture, and answer the first npairs correlations
    task automatic launch(input logic [7:0] lg [8], input logic [15:0] pk [8],
                          input int cap_dly, input int xc_dly, input bit stray,
                          input int npairs, output bit ok);
        ok = 1'b1;
        start = 1'b1; tick(); start = 1'b0;
        chk("cap_start_pulse", cap_start, 1);
        chk("busy_capture", busy, 1);
        for (int i = 0; i < cap_dly; i++) begin
            if (stray && i == 1) xc_done = 1'b1;
            tick();
            xc_done = 1'b0;
            if (i == 0) chk("cap_start_once", cap_start, 0);
        end
        cap_done = 1'b1; tick(); cap_done = 1'b0;
        for (int p = 1; p <= npairs; p++) begin
            wait_xc(ok);
            if (!ok) return;
            chk($sformatf("xc_pair_%0d", p), xc_pair, p);
            if (stray) start = 1'b1;
            tick();
            start = 1'b0;
            if (stray) cap_done = 1'b1;
            for (int d = 0; d < xc_dly; d++) begin tick(); cap_done = 1'b0; end
            cap_done = 1'b0;
            chk($sformatf("xc_pair_hold_%0d", p), xc_pair, p);
            xc_lag = lg[p]; xc_peak = pk[p]; xc_done = 1'b1;
            tick();
            xc_done = 1'b0; xc_lag = 8'($urandom); xc_peak = 16'($urandom);
        end
    endtask

    task automatic run_frame(input string tag, input logic [7:0] lg [8], input logic [15:0] pk [8],
                             input int cap_dly, input int xc_dly, input bit stray, output bit ok);
        int n;
        rx_q.delete();
        build_exp(lg, pk);
        launch(lg, pk, cap_dly, xc_dly, stray, NP, ok);
        if (!ok) return;
        n = 0;
        while (rx_q.size() < FLEN && n < 2000) begin tick(); n++; end
        chk({tag, "_len"}, rx_q.size(), FLEN);
        if (rx_q.size() != FLEN) begin ok = 1'b0; return; end
        chk({tag, "_busy_done"}, busy, 1);
        chk({tag, "_valid_done"}, tx_valid, 0);
        tick();
        chk({tag, "_busy_idle"}, busy, 0);
        chk({tag, "_err"}, err, 0);
        for (int i = 0; i < FLEN; i++)
            chk($sformatf("%s_byte%0d", tag, i), rx_q[i], exp_q[i]);
    endtask

    task automatic recover();
        rst = 1'b1; tick(); rst = 1'b0; rmode = 0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]  lg [8];
        logic [7:0]  lg_nom [8];
        logic [15:0] pk [8];
        logic [15:0] pk_all [8];
        vec_t        vt [5];
        bit          ok;
        int          tv0, xs0, n;

        rst = 1'b1; start = 0; start_t = 0; abort = 0; cap_done = 0; xc_done = 0;
        xc_lag = 0; xc_peak = 0; tx_ready = 1'b1; rmode = 0;
        tick(); tick();
        check_reset_outputs("reset");
        chk("reset_to_busy", busy_t, 0);
        rst = 1'b0;

        foreach (pk_all[i]) pk_all[i] = 16'h1234;
        // Uniform peaks on an even pair count cancel out of the checksum,
        // so these checksums hold with or without peak bytes.
        vt[0] = '{lag: '{8'h00, 8'h01, 8'hFE, 8'h03, 8'h00, 8'h05, 8'hF9, 8'h00}, rmode: 0, cap_dly: 100, csum: 8'hA5};
        vt[1] = '{lag: '{8'h00, 8'h01, 8'hFE, 8'h03, 8'h00, 8'h05, 8'hF9, 8'h00}, rmode: 1, cap_dly: 5,   csum: 8'hA5};
        vt[2] = '{lag: '{8'h00, 8'h7F, 8'h80, 8'h7F, 8'h80, 8'h7F, 8'h80, 8'h00}, rmode: 0, cap_dly: 0,   csum: 8'h5A};
        vt[3] = '{lag: '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, rmode: 1, cap_dly: 2,   csum: 8'hA5};
        vt[4] = '{lag: '{8'h00, 8'h11, 8'h22, 8'h44, 8'h88, 8'h01, 8'h02, 8'h00}, rmode: 1, cap_dly: 7,   csum: 8'h59};
        lg_nom = vt[0].lag;

        for (int v = 0; v < 5; v++) begin
            rmode = vt[v].rmode;
            run_frame($sformatf("vec%0d", v), vt[v].lag, pk_all, vt[v].cap_dly, 2, 1'b0, ok);
            if (rx_q.size() == FLEN) chk($sformatf("vec%0d_csum", v), rx_q[FLEN-1], vt[v].csum);
            if (!ok) recover();
        end
        rmode = 0;

        // Abort while waiting on the pair-3 correlation
        tv0 = tv_cnt;
        launch(lg_nom, pk_all, 4, 1, 1'b0, 2, ok);
        if (ok) wait_xc(ok);
        if (ok) begin
            chk("abxc_pair", xc_pair, 3);
            tick();
            chk("abxc_wait_busy", busy, 1);
            abort = 1'b1; cap_done = 1'b1; tick(); abort = 1'b0; cap_done = 1'b0;
            chk("abxc_busy", busy, 0);
            chk("abxc_err", err, 0);
            xc_done = 1'b1; tick(); xc_done = 1'b0;
            chk("abxc_stray_done", busy, 0);
            repeat (5) tick();
            chk("abxc_no_tx", tv_cnt, tv0);
        end else recover();

        // Abort while byte 2 is being held by tx_ready=0
        rmode = 2; tx_ready = 1'b0;
        rx_q.delete();
        build_exp(lg_nom, pk_all);
        launch(lg_nom, pk_all, 3, 1, 1'b0, NP, ok);
        n = 0;
        while (!tx_valid && n < 50) begin tick(); n++; end
        chk("abtx_valid", tx_valid, 1);
        tx_ready = 1'b1; tick(); tick(); tx_ready = 1'b0;
        chk("abtx_byte2", tx_data, exp_q[2]);
        abort = 1'b1; tick(); abort = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("abtx_hold_valid", tx_valid, 1);
            chk("abtx_hold_byte2", tx_data, exp_q[2]);
            tick();
        end
        tx_ready = 1'b1; tick();
        chk("abtx_busy", busy, 0);
        chk("abtx_valid_low", tx_valid, 0);
        chk("abtx_err", err, 0);
        chk("abtx_count", rx_q.size(), 3);
        for (int i = 0; i < 3 && i < rx_q.size(); i++)
            chk($sformatf("abtx_byte%0d", i), rx_q[i], exp_q[i]);
        rmode = 0;

        // Reset in the middle of the TX phase, then a clean frame
        rmode = 2; tx_ready = 1'b0;
        launch(lg_nom, pk_all, 1, 0, 1'b0, NP, ok);
        n = 0;
        while (!tx_valid && n < 50) begin tick(); n++; end
        chk("rsttx_valid", tx_valid, 1);
        tx_ready = 1'b1; tick();
        rst = 1'b1; tick(); rst = 1'b0;
        check_reset_outputs("rsttx");
        rmode = 0;
        run_frame("after_rst", lg_nom, pk_all, 3, 1, 1'b0, ok);
        if (!ok) recover();

        // Capture timeout on the TIMEOUT=50 instance
        xs0 = xs_t_cnt;
        start_t = 1'b1; tick(); start_t = 1'b0;
        chk("to_cap_start", cap_start_t, 1);
        repeat (49) tick();
        chk("to_err_c49", err_t, 0);
        chk("to_busy_c49", busy_t, 1);
        tick();
        chk("to_err_c50", err_t, 1);
        chk("to_busy_c50", busy_t, 0);
        chk("to_no_xc_start", xs_t_cnt, xs0);
        chk("to_tx_valid", tx_valid_t, 0);
        chk("to_tx_data", tx_data_t, 0);
        chk("to_xc_pair", xc_pair_t, 0);
        tick();
        chk("to_err_sticky", err_t, 1);
        start_t = 1'b1; tick(); start_t = 1'b0;
        chk("to_err_cleared", err_t, 0);
        abort = 1'b1; tick(); abort = 1'b0;
        chk("to_abort_idle", busy_t, 0);

        // Start together with abort stays idle
        start = 1'b1; abort = 1'b1; tick(); start = 1'b0; abort = 1'b0;
        chk("start_abort_busy", busy, 0);
        chk("start_abort_cap", cap_start, 0);

        // Randomized frames with stray pulses that must be ignored
        for (int r = 0; r < 8; r++) begin
            for (int p = 0; p < 8; p++) begin
                lg[p] = 8'($urandom);
                pk[p] = 16'($urandom);
            end
            rmode = int'($urandom_range(0, 1));
            run_frame($sformatf("rnd%0d", r), lg, pk, int'($urandom_range(2, 20)),
                      int'($urandom_range(0, 4)), 1'b1, ok);
            if (!ok) recover();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
